// File: rtl/ddr3_wb_arbiter.sv
// Two-master pipelined Wishbone arbiter feeding the single DDR3 controller user port.
// Round-robin grant per beat; a tag FIFO steers each controller ack back to its issuer in order.
module ddr3_wb_arbiter #(
  parameter int ADDR_BITS  = 24,
  parameter int DATA_BITS  = 128,
  parameter int SEL_BITS   = DATA_BITS / 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,

  input  logic                 i_m0_cyc,
  input  logic                 i_m0_stb,
  input  logic                 i_m0_we,
  input  logic [ADDR_BITS-1:0] i_m0_addr,
  input  logic [DATA_BITS-1:0] i_m0_data,
  input  logic [SEL_BITS-1:0]  i_m0_sel,
  output logic                 o_m0_stall,
  output logic                 o_m0_ack,
  output logic [DATA_BITS-1:0] o_m0_data,

  input  logic                 i_m1_cyc,
  input  logic                 i_m1_stb,
  input  logic                 i_m1_we,
  input  logic [ADDR_BITS-1:0] i_m1_addr,
  input  logic [DATA_BITS-1:0] i_m1_data,
  input  logic [SEL_BITS-1:0]  i_m1_sel,
  output logic                 o_m1_stall,
  output logic                 o_m1_ack,
  output logic [DATA_BITS-1:0] o_m1_data,

  output logic                 o_s_cyc,
  output logic                 o_s_stb,
  output logic                 o_s_we,
  output logic [ADDR_BITS-1:0] o_s_addr,
  output logic [DATA_BITS-1:0] o_s_data,
  output logic [SEL_BITS-1:0]  o_s_sel,
  input  logic                 i_s_stall,
  input  logic                 i_s_ack,
  input  logic [DATA_BITS-1:0] i_s_data,

  output logic                 o_busy,
  output logic                 o_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic                  req0;
  logic                  req1;
  logic                  grant_valid;
  logic                  grant_idx;
  logic                  fifo_full;
  logic                  accept;
  logic                  pending;
  logic                  pop;
  logic                  spurious;
  logic                  head;
  logic                  src_m1;
  logic                  rr_last;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH-1:0]      tag_mem;

  // Arbitration and acceptance are purely combinational: zero added latency.
  assign req0        = i_m0_cyc & i_m0_stb;
  assign req1        = i_m1_cyc & i_m1_stb;
  assign grant_valid = (req0 | req1) & ~i_rst;
  assign grant_idx   = (req0 & req1) ? ~rr_last : req1;
  assign fifo_full   = (count == FULL_COUNT);
  assign accept      = grant_valid & ~i_s_stall & ~fifo_full;

  assign pending  = (count != '0);
  assign pop      = i_s_ack & pending & ~i_rst;
  assign spurious = i_s_ack & ~pending;
  assign head     = tag_mem[rd_ptr];

  // Slave side; an idle beat still presents master 0's fields.
  assign o_s_stb  = grant_valid & ~fifo_full;
  assign src_m1   = o_s_stb & grant_idx;
  assign o_s_we   = src_m1 ? i_m1_we   : i_m0_we;
  assign o_s_addr = src_m1 ? i_m1_addr : i_m0_addr;
  assign o_s_data = src_m1 ? i_m1_data : i_m0_data;
  assign o_s_sel  = src_m1 ? i_m1_sel  : i_m0_sel;
  assign o_s_cyc  = i_m0_cyc | i_m1_cyc | pending;

  assign o_m0_stall = ~(accept & ~grant_idx);
  assign o_m1_stall = ~(accept &  grant_idx);

  // Acks for a master that dropped cyc are popped but not forwarded.
  assign o_m0_ack  = pop & ~head & i_m0_cyc;
  assign o_m1_ack  = pop &  head & i_m1_cyc;
  assign o_m0_data = i_s_data;
  assign o_m1_data = i_s_data;

  assign o_busy = pending;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rr_last <= 1'b1;
      o_err   <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr  <= wr_ptr + 1'b1;
        rr_last <= grant_idx;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (spurious) begin
        o_err <= 1'b1;
      end
    end
  end

  // Tag storage carries no reset; validity is tracked solely by count.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      tag_mem[wr_ptr] <= grant_idx;
    end
  end

endmodule

// File: doc/ddr3_wb_arbiter.md
Name: ddr3_wb_arbiter

Overview:
- Two-master pipelined Wishbone arbiter in front of the single user port of the DDR3 controller. The DDR3 controller runs on i_controller_clk at 83.333 MHz with a 4:1 ratio.
- Master 0 is the mkTop core memory port. Master 1 is the UART debug/loader port.
- Grants one request per cycle, round-robin on contention, and keeps a tag FIFO of accepted requests. Each controller ack and its read data are returned to the master that issued the request, in order.

Parameters:
- ADDR_BITS, 24, burst-addressable {row,bank,col} width on all ports.
- DATA_BITS, 128, data width on all ports (8 x 16 DQ pins for 4:1).
- SEL_BITS, DATA_BITS/8, byte-strobe width.
- DEPTH_LOG2, 3, log2 of tag FIFO depth (max outstanding = 2^DEPTH_LOG2 = 8).

Ports:
- i_clk  in  1  controller clock; all logic on rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_m0_cyc, i_m0_stb, i_m0_we  in  1 each  master 0 cycle, strobe, write-enable.
- i_m0_addr  in  ADDR_BITS  master 0 address.
- i_m0_data  in  DATA_BITS  master 0 write data.
- i_m0_sel  in  SEL_BITS  master 0 byte strobes.
- o_m0_stall, o_m0_ack  out  1 each  master 0 stall and ack.
- o_m0_data  out  DATA_BITS  master 0 read data.
- i_m1_* / o_m1_*  same set, widths and meanings as master 0, for master 1.
- o_s_cyc, o_s_stb, o_s_we  out  1 each  to controller.
- o_s_addr  out  ADDR_BITS  to controller.
- o_s_data  out  DATA_BITS  to controller.
- o_s_sel  out  SEL_BITS  to controller.
- i_s_stall, i_s_ack  in  1 each  from controller.
- i_s_data  in  DATA_BITS  controller read data.
- o_busy  out  1  tag FIFO non-empty.
- o_err  out  1  sticky: ack received with empty FIFO.

Behaviour:
- Reset (sync, i_rst=1 at edge):
  - FIFO count, read and write pointers cleared to 0; rr_last cleared to 1 (so master 0 wins first contention); o_err cleared to 0.
  - During and after reset: all o_*_ack=0, o_s_stb=0, o_*_stall=1 while i_rst is high.
- Request qualification: req_k = i_mk_cyc & i_mk_stb.
- Arbitration is combinational, per cycle:
  - Only one requester: it is granted.
  - Both request: grant the master not equal to rr_last.
  - rr_last updates to the granted index only on acceptance.
- Acceptance: accept = grant_valid & ~i_s_stall & ~fifo_full.
  - On accept: push granted index into the FIFO.
  - The request occupies exactly one slave beat.
- Slave outputs:
  - o_s_stb = grant_valid & ~fifo_full.
  - o_s_addr, o_s_data, o_s_sel, o_s_we are muxed from the granted master; they are don't-care when o_s_stb=0 and driven from master 0 in that case.
  - o_s_cyc = i_m0_cyc | i_m1_cyc | (count != 0).
- Master stall:
  - o_mk_stall = 1 unless master k is granted and accept is true that cycle.
  - A non-requesting master sees stall=1, which is legal Wishbone.
- Zero added latency: controller acceptance and master acceptance happen in the same cycle.
- Ack routing:
  - On i_s_ack with count != 0: pop the FIFO head h.
  - o_mh_ack = i_s_ack & i_mh_cyc; o_mh_data = i_s_data.
  - This path is combinational, same cycle as i_s_ack.
  - o_mk_data for the non-acked master holds i_s_data and is don't-care.
- Dropped cycle: if master h has deasserted cyc while it has requests outstanding:
  - its acks are still popped but not forwarded (ack suppressed);
  - the other master is unaffected.
- Spurious ack: i_s_ack with count == 0 sets o_err=1 (sticky until reset); no pop, no ack forwarded.
- Simultaneous push and pop in one cycle: count unchanged; both pointers advance (mod 2^DEPTH_LOG2).
- Full: count == 2^DEPTH_LOG2.
  - o_s_stb=0 and both masters are stalled.
  - An ack popping in the same cycle does not lift the stall until the next cycle; fifo_full uses the registered count.
- Pointer wrap: DEPTH_LOG2-bit pointers wrap naturally. count is DEPTH_LOG2+1 bits.
- Reset mid-operation: outstanding tags are discarded; the controller is reset by the same i_rst, so no late acks are expected. A late ack sets o_err.
- o_busy = (count != 0), registered-count based.

Test Plan:
- Single master: m0 issues 4 reads to addrs 0x10-0x13 with the controller acking after 6 cycles each. Required: 4 m0 acks in order, data matching, m1 ack never asserted, count returns to 0, o_busy falls.
- Contention: m0 and m1 both hold stb for 6 cycles, no stall. Required: grants alternate m0,m1,m0,m1,m0,m1 starting with m0 after reset; each ack is routed to the issuing master in issue order.
- Backpressure: i_s_stall=1 for 5 cycles while both request. Required: o_s_stb=1 while i_s_stall=1, both o_mk_stall=1, no FIFO push; the grant order resumes correctly when the stall drops.
- Full FIFO: controller withholds acks; m0 streams requests. Required: exactly 8 accepted, 9th stalled with o_s_stb=0. One ack issued: the stall releases on the following cycle and the 9th is accepted.
- Dropped cyc: m1 issues 2 reads, then deasserts cyc before the acks. Required: both acks are popped, o_m1_ack stays 0, m0 traffic interleaved with them still acks correctly.
- Spurious ack and reset: i_s_ack pulsed with empty FIFO -> o_err=1 and it stays 1. i_rst asserted with 3 outstanding requests -> count=0, o_err=0, rr_last=1 the next cycle.
